// File: rtl/arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arbiter_pkg
// Shared types and constants for the 8-channel round-robin arbiter.
//   N_REQ   number of requesters
//   IDX_W   width of a requester index
//   HOLD_W  width of the tenure counter
//   arb_state_e  FSM encoding (IDLE=0, GRANT=1)
// ---------------------------------------------------------------------------
package arbiter_pkg;

    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Bits strictly below idx set; this is what makes the priority rotate.
    function automatic logic [N_REQ-1:0] below_mask(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] m;
        m = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i < int'(idx)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/arbiter_rr_8ch_if.sv
// ---------------------------------------------------------------------------
// arbiter_rr_8ch_if
// Request/grant bundle between the requesters and the arbiter.
//   req        requester -> arbiter, one bit per requester
//   gnt        arbiter -> requester, one-hot grant
//   gnt_idx    arbiter -> requester, binary owner index
//   gnt_valid  arbiter -> requester, a grant is active
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface arbiter_rr_8ch_if;
    import arbiter_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;

    modport master (output req, input gnt, input gnt_idx, input gnt_valid);
    modport slave  (input req, output gnt, output gnt_idx, output gnt_valid);

endinterface

// File: rtl/priority_encoder_8x3.sv
// ---------------------------------------------------------------------------
// priority_encoder_8x3
// 8-to-3 priority encoder, highest set bit wins.
//   in    8-bit input vector
//   idx   index of the highest set bit (0 when in is zero)
//   idle  high when in is all zeros
// ---------------------------------------------------------------------------
module priority_encoder_8x3
    import arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] in,
    output logic [IDX_W-1:0] idx,
    output logic             idle
);

    // Ascending scan: later (higher) hits overwrite earlier ones.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (in[i]) idx = i[IDX_W-1:0];
        end
        idle = ~|in;
    end

endmodule

// File: rtl/arbiter_rr_8ch.sv
// ---------------------------------------------------------------------------
// arbiter_rr_8ch
// Round-robin arbiter for 8 requesters with a bounded grant tenure.
//   MAX_HOLD  max consecutive grant cycles per tenure (0 = unlimited)
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   bus       arbiter_rr_8ch_if.slave: req in; gnt, gnt_idx, gnt_valid out
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; arbitrate on req, grant on the next edge
// GRANT | owner holds the resource until req[owner] drops or tenure ends
// ---------------------------------------------------------------------------
module arbiter_rr_8ch
    import arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    arbiter_rr_8ch_if.slave  bus
);

    localparam bit                LIMITED   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LIMITED ? MAX_HOLD - 1 : 0);

    arb_state_e        state;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  last;
    logic [HOLD_W-1:0] hold_cnt;
    logic [N_REQ-1:0]  gnt_r;
    logic [IDX_W-1:0]  gnt_idx_r;
    logic              gnt_valid_r;

    logic [N_REQ-1:0]  mask;
    logic [IDX_W-1:0]  mask_idx;
    logic [IDX_W-1:0]  raw_idx;
    logic              mask_idle;
    logic              raw_idle;
    logic [IDX_W-1:0]  winner;
    logic              tenure_end;

    assign mask = bus.req & below_mask(last);

    priority_encoder_8x3 u_pe_mask (
        .in   (mask),
        .idx  (mask_idx),
        .idle (mask_idle)
    );

    priority_encoder_8x3 u_pe_raw (
        .in   (bus.req),
        .idx  (raw_idx),
        .idle (raw_idle)
    );

    // Nothing pending below the last owner: wrap around to the top of req.
    assign winner     = mask_idle ? raw_idx : mask_idx;
    assign tenure_end = LIMITED && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= '0;
            last        <= '0;
            hold_cnt    <= '0;
            gnt_r       <= '0;
            gnt_idx_r   <= '0;
            gnt_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!raw_idle) begin
                        state       <= GRANT;
                        owner       <= winner;
                        gnt_r       <= onehot(winner);
                        gnt_idx_r   <= winner;
                        gnt_valid_r <= 1'b1;
                        hold_cnt    <= '0;
                    end
                end
                GRANT: begin
                    if (!bus.req[owner] || tenure_end) begin
                        state       <= IDLE;
                        gnt_r       <= '0;
                        gnt_idx_r   <= '0;
                        gnt_valid_r <= 1'b0;
                        last        <= owner;
                    end else if (hold_cnt != '1) begin
                        // Only reachable at 255 in unlimited mode; saturate there.
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_idx   = gnt_idx_r;
    assign bus.gnt_valid = gnt_valid_r;

endmodule

// File: tb/tb_arbiter_rr_8ch.sv
module tb_arbiter_rr_8ch;
    import arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arbiter_rr_8ch_if b16 ();
    arbiter_rr_8ch_if b4 ();
    arbiter_rr_8ch_if b0 ();

    arbiter_rr_8ch #(.MAX_HOLD(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    arbiter_rr_8ch #(.MAX_HOLD(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));
    arbiter_rr_8ch #(.MAX_HOLD(0))  dut0  (.clk(clk), .rst(rst), .bus(b0));

    typedef struct {
        int          due;
        int          inst;
        logic [7:0]  gnt;
        logic [2:0]  idx;
        logic        v;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops every expectation that falls due in this cycle.
    exp_t       m_e;
    logic [7:0] m_g;
    logic [2:0] m_i;
    logic       m_v;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            m_e = sb.pop_front();
            case (m_e.inst)
                16:      begin m_g = b16.gnt; m_i = b16.gnt_idx; m_v = b16.gnt_valid; end
                4:       begin m_g = b4.gnt;  m_i = b4.gnt_idx;  m_v = b4.gnt_valid;  end
                default: begin m_g = b0.gnt;  m_i = b0.gnt_idx;  m_v = b0.gnt_valid;  end
            endcase
            vectors++;
            if (m_g !== m_e.gnt || m_i !== m_e.idx || m_v !== m_e.v) begin
                miscompares++;
                $display("FAIL %s (dut%0d cyc %0d): got gnt=%b idx=%0d valid=%b, want gnt=%b idx=%0d valid=%b",
                         m_e.nm, m_e.inst, cyc, m_g, m_i, m_v, m_e.gnt, m_e.idx, m_e.v);
            end
        end
    end

    task automatic push(input int inst, input logic [7:0] eg, input logic [2:0] ei,
                        input logic ev, input string nm);
        exp_t e;
        e = '{cyc + 1, inst, eg, ei, ev, nm};
        sb.push_back(e);
    endtask

    // Apply req to one DUT for the next edge and record what must appear after it.
    task automatic drive(input int inst, input logic [7:0] r, input logic [7:0] eg,
                         input logic [2:0] ei, input logic ev, input string nm);
        case (inst)
            16:      b16.req = r;
            4:       b4.req  = r;
            default: b0.req  = r;
        endcase
        push(inst, eg, ei, ev, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic grant(input int inst, input logic [7:0] r, input int k, input string nm);
        logic [7:0] g;
        g = 8'h01 << k;
        drive(inst, r, g, k[2:0], 1'b1, nm);
    endtask

    task automatic idle(input int inst, input logic [7:0] r, input string nm);
        drive(inst, r, 8'h00, 3'd0, 1'b0, nm);
    endtask

    initial begin
        rst    = 1'b1;
        b16.req = '0;
        b4.req  = '0;
        b0.req  = '0;
        @(posedge clk);
        #1;

        // Reset wins over a pending request
        push(4, 8'h00, 3'd0, 1'b0, "reset_dut4");
        push(0, 8'h00, 3'd0, 1'b0, "reset_dut0");
        idle(16, 8'b0010_0101, "reset_dominates");
        rst = 1'b0;

        // Rotation with MAX_HOLD=16
        grant(16, 8'b0010_0101, 5, "first_grant");
        grant(16, 8'b0010_0101, 5, "hold5_a");
        grant(16, 8'b0010_0101, 5, "hold5_b");
        idle (16, 8'b0000_0101,    "drop5_gap");
        grant(16, 8'b0000_0101, 2, "rot_to2");
        grant(16, 8'b0000_0101, 2, "hold2");
        idle (16, 8'b0000_0001,    "drop2_gap");
        grant(16, 8'b0000_0001, 0, "rot_to0");
        idle (16, 8'b1000_0010,    "drop0_gap");
        grant(16, 8'b1000_0010, 7, "wrap_to7");
        grant(16, 8'b1100_0010, 7, "ignore_new6");
        idle (16, 8'b0100_0010,    "drop7_gap");
        grant(16, 8'b0100_0010, 6, "rot_to6");
        idle (16, 8'b0000_0000,    "drop6_gap");
        grant(16, 8'b0100_0000, 6, "regrant6");
        rst = 1'b1;
        idle (16, 8'b0100_0001,    "rst_mid_tenure");
        rst = 1'b0;
        grant(16, 8'b0100_0001, 6, "ptr_reset");
        idle (16, 8'b0000_0000,    "release6");
        for (int i = 0; i < 20; i++) idle(16, 8'h00, "no_req");

        // MAX_HOLD=4, all requesting
        for (int k = 7; k >= 0; k--) begin
            for (int j = 0; j < 4; j++) grant(4, 8'hFF, k, "hold4_rot");
            idle(4, 8'hFF, "hold4_gap");
        end
        for (int j = 0; j < 4; j++) grant(4, 8'hFF, 7, "hold4_wrap7");
        idle(4, 8'h10, "drop_to4");
        for (int rep = 0; rep < 2; rep++) begin
            for (int j = 0; j < 4; j++) grant(4, 8'h10, 4, "persist4");
            idle(4, 8'h10, "persist4_gap");
        end
        b4.req = '0;

        // MAX_HOLD=0, unlimited tenure; other bits churn
        grant(0, 8'h08, 3, "unlim_first");
        for (int i = 1; i < 100; i++)
            grant(0, 8'h08 | (8'($urandom) & 8'hF7), 3, "unlim_hold");
        idle (0, 8'h80,    "unlim_drop");
        grant(0, 8'h80, 7, "after_unlim");
        b0.req = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
            miscompares += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
